// File: rtl/sm83_bus_unit.sv
// sm83_bus_unit: SM83 bus interface (T1..T4 sequencer, rd/wr strobes, address pins, data latch, IR, NREG mapped regs); define SM83_BUS_WAIT_EN for ext_ready wait states
module sm83_bus_unit #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int NREG = 1,
  parameter logic [AW-1:0] REG_BASE = 'hffff,
  parameter int HI_ZERO = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               t1,
  output logic               t2,
  output logic               t3,
  output logic               t4,
  output logic               stall,
  input  logic               mread,
  input  logic               mwrite,
  input  logic [AW-1:0]      ain,
  input  logic               apin_we,
  output logic [AW-1:0]      aout,
  input  logic [DW-1:0]      din,
  input  logic               dl_we,
  input  logic               zero_data,
  output logic [DW-1:0]      dout,
  input  logic [DW-1:0]      ext_din,
  output logic [DW-1:0]      ext_dout,
  input  logic               ext_ready,
  output logic               rd,
  output logic               wr,
  output logic [NREG*DW-1:0] reg_q,
  input  logic               ir_we,
  input  logic               ir_bank_we,
  input  logic               ir_bank_cb_set,
  output logic [7:0]         opcode,
  output logic               bank_cb
);
  typedef enum logic [1:0] {T1, T2, T3, T4} phase_t;
  localparam logic [AW-1:0] KEEP = {AW{1'b1}} >> HI_ZERO;
  phase_t phase, phase_nxt;
  logic [DW-1:0] latch, reg_rd, data_t4;
  logic [7:0] opcode_r;
  logic [AW-1:0] off;
  logic hit, hold;
`ifdef SM83_BUS_WAIT_EN
  assign hold = (rd | wr) & ~ext_ready;
`else
  logic unused;
  assign unused = ext_ready;
  assign hold = 1'b0;
`endif
  assign t1 = phase == T1;
  assign t2 = phase == T2;
  assign t3 = phase == T3;
  assign t4 = phase == T4;
  assign stall = t3 & hold;
  assign off = aout - REG_BASE;
  assign hit = aout >= REG_BASE && off < AW'(NREG);
  assign data_t4 = zero_data ? '0 : hit ? reg_rd : ext_din;
  assign dout = (rd & t4) ? data_t4 : latch;
  assign ext_dout = latch;
  assign opcode = ir_we ? 8'(data_t4) : opcode_r;
  always_comb begin
    reg_rd = '0;
    for (int i = 0; i < NREG; i++)
      reg_rd = (off == AW'(i)) ? reg_q[i*DW +: DW] : reg_rd;
  end
  always_comb phase_nxt = t4 ? T1 : (t3 && hold) ? T3 : phase_t'(phase + 2'd1);
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= T1;
      rd <= 1'b0;
      wr <= 1'b0;
      aout <= '0;
      latch <= '0;
      reg_q <= '0;
      opcode_r <= '0;
      bank_cb <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (t4) begin
        rd <= mread;
        wr <= mwrite & ~mread;
      end
      aout <= apin_we ? ain : t4 ? aout & KEEP : aout;
      latch <= zero_data ? '0 : dl_we ? din : (rd & t4) ? data_t4 : latch;
      if (ir_we) opcode_r <= 8'(data_t4);
      if (ir_bank_we) bank_cb <= ir_bank_cb_set;
      for (int i = 0; i < NREG; i++)
        if (t4 && wr && hit && off == AW'(i)) reg_q[i*DW +: DW] <= latch;
    end
  end
endmodule
